adder_result_accumulator: RTL and testbench

//   Downstream consumer of tt_um_four_bit_adder results. Accepts each 5-bit

---
 rtl/adder_result_accumulator.sv | 146 ++++++++++++++
 tb/tb_adder_result_accumulator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_accumulator.sv
// ============================================================================
// adder_result_accumulator
// ----------------------------------------------------------------------------
// Purpose:
//   Collects 5-bit adder results {cout,sum[3:0]} over a valid/ready handshake.
//   Each group of BATCH results is summed into an ACC_W-bit accumulator. The
//   group total is then offered downstream over a second valid/ready
//   handshake. While the total waits in DRAIN, no further input is taken.
//
// Optional feature macro: SATURATE_EN
//   defined   : the accumulator clamps at 2^ACC_W-1 after the first overflow
//               and stays clamped for the rest of the batch.
//   undefined : the accumulator wraps modulo 2^ACC_W (default).
//   In both modes out_ovf reports that the batch exceeded 2^ACC_W-1.
//
// Parameters:
//   ACC_W  accumulator / out_acc width in bits (>= 5)
//   BATCH  results per batch (>= 1)
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   ena        in   1      enable; 0 freezes all handshakes and state
//   clear      in   1      synchronous abort of the current batch
//   in_valid   in   1      adder result valid
//   in_ready   out  1      result can be accepted this cycle (combinational)
//   in_sum     in   4      adder sum bits
//   in_cout    in   1      adder carry out
//   out_valid  out  1      batch total available
//   out_ready  in   1      consumer accepts the total
//   out_acc    out  ACC_W  batch total
//   out_ovf    out  1      batch exceeded 2^ACC_W-1
//   busy       out  1      batch in progress or total waiting in DRAIN
// ============================================================================
module adder_result_accumulator #(
    parameter int ACC_W = 8,
    parameter int BATCH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(BATCH + 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;
    logic               out_valid_reg;
    logic [ACC_W-1:0]   out_acc_reg;
    logic               out_ovf_reg;

    logic [ACC_W:0]     value_ext;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_next;
    logic               accept;
    logic               last_accept;
    logic               drain_hs;

    // ------------------------------------------------------------------------
    // Datapath: one extra bit above the accumulator catches the carry that
    // marks an overflow for this add.
    // ------------------------------------------------------------------------
    assign value_ext = {{(ACC_W - 4){1'b0}}, in_cout, in_sum};
    assign sum_ext   = {1'b0, acc_reg} + value_ext;
    assign ovf_next  = ovf_reg | sum_ext[ACC_W];

`ifdef SATURATE_EN
    // Once the batch has overflowed, the total is pinned at full scale.
    assign acc_next  = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next  = sum_ext[ACC_W-1:0];
`endif

    // ------------------------------------------------------------------------
    // Handshake decode. clear masks in_ready so a sample offered together
    // with clear is visibly refused rather than silently dropped.
    // ------------------------------------------------------------------------
    assign in_ready    = ena & ~clear & (state_reg == ST_ACCUM);
    assign accept      = in_valid & in_ready;
    assign last_accept = (cnt_reg == CNT_W'(BATCH - 1));
    assign drain_hs    = ena & out_valid_reg & out_ready & (state_reg == ST_DRAIN);

    // ------------------------------------------------------------------------
    // Control and state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_acc_reg   <= '0;
            out_ovf_reg   <= 1'b0;
        end else if (clear) begin
            // Abort works even with ena low; the last published total stays.
            state_reg     <= ST_ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_accept) begin
                out_acc_reg   <= acc_next;
                out_ovf_reg   <= ovf_next;
                out_valid_reg <= 1'b1;
                state_reg     <= ST_DRAIN;
            end
        end else if (drain_hs) begin
            // out_acc/out_ovf are left alone so the consumer can still read
            // the previous total until the next batch completes.
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
            state_reg     <= ST_ACCUM;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_acc   = out_acc_reg;
    assign out_ovf   = out_ovf_reg;
    assign busy      = (cnt_reg != '0) | (state_reg == ST_DRAIN);

endmodule

// File: tb/tb_adder_result_accumulator.sv
// ============================================================================
// tb_adder_result_accumulator
// ----------------------------------------------------------------------------
// Three instances share one stimulus stream:
//   k=0 : ACC_W=8, BATCH=4
//   k=1 : ACC_W=6, BATCH=4   (overflows readily)
//   k=2 : ACC_W=8, BATCH=1
// The reference model keeps, per instance, the true (unbounded) sum of the
// current batch and the number of results taken; the published total is
// derived from that true sum when the batch completes.
// ============================================================================
module tb_adder_result_accumulator;

    localparam int NK = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_sum = 4'd0;
    logic in_cout = 1'b0;
    logic out_ready = 1'b0;

    logic [NK-1:0] d_ready;
    logic [NK-1:0] d_valid;
    logic [NK-1:0] d_ovf;
    logic [NK-1:0] d_busy;
    logic [7:0] acc0;
    logic [5:0] acc1;
    logic [7:0] acc2;

    int n_tests = 0;
    int n_fail  = 0;

    int cfg_w [NK] = '{8, 6, 8};
    int cfg_b [NK] = '{4, 4, 1};

    // Reference model state
    int m_sum     [NK];
    int m_cnt     [NK];
    int m_out_acc [NK];
    bit m_drain   [NK];
    bit m_ovf     [NK];

    always #5 clk = ~clk;

    adder_result_accumulator #(.ACC_W(8), .BATCH(4)) u_main (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(d_ready[0]),
        .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(d_valid[0]), .out_ready(out_ready),
        .out_acc(acc0), .out_ovf(d_ovf[0]), .busy(d_busy[0])
    );

    adder_result_accumulator #(.ACC_W(6), .BATCH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(d_ready[1]),
        .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(d_valid[1]), .out_ready(out_ready),
        .out_acc(acc1), .out_ovf(d_ovf[1]), .busy(d_busy[1])
    );

    adder_result_accumulator #(.ACC_W(8), .BATCH(1)) u_single (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(d_ready[2]),
        .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(d_valid[2]), .out_ready(out_ready),
        .out_acc(acc2), .out_ovf(d_ovf[2]), .busy(d_busy[2])
    );

    function automatic int get_acc(int k);
        case (k)
            0:       return int'(acc0);
            1:       return int'(acc1);
            default: return int'(acc2);
        endcase
    endfunction

    function automatic int full_scale(int k);
        return (1 << cfg_w[k]) - 1;
    endfunction

    // Published total for a batch whose true sum is s.
    function automatic int model_total(int k, int s);
`ifdef SATURATE_EN
        return (s > full_scale(k)) ? full_scale(k) : s;
`else
        return s & full_scale(k);
`endif
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model update
    // ------------------------------------------------------------------------
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NK; k++) begin
            if (!rst_n) begin
                m_sum[k]     <= 0;
                m_cnt[k]     <= 0;
                m_drain[k]   <= 1'b0;
                m_out_acc[k] <= 0;
                m_ovf[k]     <= 1'b0;
            end else if (clear) begin
                m_sum[k]   <= 0;
                m_cnt[k]   <= 0;
                m_drain[k] <= 1'b0;
            end else if (ena) begin
                if (!m_drain[k] && in_valid) begin
                    m_sum[k] <= m_sum[k] + int'({in_cout, in_sum});
                    m_cnt[k] <= m_cnt[k] + 1;
                    if (m_cnt[k] + 1 == cfg_b[k]) begin
                        m_drain[k]   <= 1'b1;
                        m_out_acc[k] <= model_total(k, m_sum[k] + int'({in_cout, in_sum}));
                        m_ovf[k]     <= (m_sum[k] + int'({in_cout, in_sum})) > full_scale(k);
                    end
                end else if (m_drain[k] && out_ready) begin
                    m_drain[k] <= 1'b0;
                    m_sum[k]   <= 0;
                    m_cnt[k]   <= 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: every falling edge, all instances, all outputs.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            automatic bit exp_ready = ena & ~clear & ~m_drain[k];
            automatic bit exp_busy  = (m_cnt[k] != 0) | m_drain[k];
            n_tests++;
            if (d_ready[k] != exp_ready || d_valid[k] != m_drain[k] ||
                get_acc(k) != m_out_acc[k] || d_ovf[k] != m_ovf[k] ||
                d_busy[k] != exp_busy) begin
                n_fail++;
                $display("FAIL cycle_cmp k=%0d at %0t: got rdy=%0b vld=%0b acc=%0d ovf=%0b busy=%0b, expected rdy=%0b vld=%0b acc=%0d ovf=%0b busy=%0b",
                         k, $time, d_ready[k], d_valid[k], get_acc(k), d_ovf[k], d_busy[k],
                         exp_ready, m_drain[k], m_out_acc[k], m_ovf[k], exp_busy);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers; all driving happens 1 time unit after a rising edge.
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #1;
        check("reset_out_valid", int'(d_valid[0]), 0);
        check("reset_out_acc", int'(acc0), 0);
        check("reset_busy", int'(d_busy[0]), 0);
        step();
        rst_n = 1'b1;
        ena = 1'b1;

        // Back-to-back 3,5,7,9
        out_ready = 1'b1;
        do_reset();
        send(3); send(5); send(7);
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'd9;
        step();
        check("b2b_out_valid", int'(d_valid[0]), 1);
        check("b2b_out_acc", int'(acc0), 24);
        check("b2b_out_ovf", int'(d_ovf[0]), 0);
        check("b2b_drain_ready", int'(d_ready[0]), 0);
        step();                                 // drain edge; offered value ignored
        in_valid = 1'b0;
        check("b2b_drained", int'(d_valid[0]), 0);
        check("b2b_ready_again", int'(d_ready[0]), 1);

        // Four x 31 into a 6-bit accumulator
        do_reset();
        out_ready = 1'b0;
        repeat (4) send(31);
`ifdef SATURATE_EN
        check("w6_out_acc", int'(acc1), 63);
`else
        check("w6_out_acc", int'(acc1), 60);
`endif
        check("w6_out_ovf", int'(d_ovf[1]), 1);
        check("w8_out_acc_124", int'(acc0), 124);
        check("w8_out_ovf_124", int'(d_ovf[0]), 0);

        // Backpressure hold
        do_reset();
        out_ready = 1'b0;
        send(10); send(20); send(30); send(31);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", int'(d_valid[0]), 1);
            check("hold_in_ready", int'(d_ready[0]), 0);
            check("hold_out_acc", int'(acc0), 91);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("hold_released", int'(d_valid[0]), 0);
        check("hold_acc_kept", int'(acc0), 91);

        // Async reset in the middle of DRAIN
        out_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", int'(d_valid[0]), 0);
        check("async_rst_out_acc", int'(acc0), 0);
        check("async_rst_busy", int'(d_busy[0]), 0);
        step();
        rst_n = 1'b1;
        #1;
        check("async_rst_in_ready", int'(d_ready[0]), 1);

        // Clear drops the sample offered with it
        out_ready = 1'b1;
        send(2); send(3);
        clear = 1'b1;
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'd7;
        #1;
        check("clear_in_ready", int'(d_ready[0]), 0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", int'(d_busy[0]), 0);
        repeat (4) send(1);
        check("clear_then_four_ones", int'(acc0), 4);
        step();

        // ena=0 freezes everything
        send(5);
        ena = 1'b0;
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ena0_in_ready", int'(d_ready[0]), 0);
            step();
        end
        ena = 1'b1;
        send(1); send(1); send(1);
        check("ena0_total", int'(acc0), 8);
        check("ena0_valid", int'(d_valid[0]), 1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            ena       = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            {in_cout, in_sum} = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        clear = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
